// File: rtl/lfsr_checker_if.sv
// Receive-side bundle for the PN checker: serial PN input, error-count clear, and status outputs.
interface lfsr_checker_if;
  logic        din;
  logic        din_valid;
  logic        clr_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;

  modport master (output din, din_valid, clr_err, input  locked, err_pulse, err_cnt);
  modport slave  (input  din, din_valid, clr_err, output locked, err_pulse, err_cnt);
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 6-bit XNOR PN stream (x[n] = x[n-5] XNOR x[n-6]).
// It hunts for alignment, locks, flywheels through bit errors, and drops lock on too many errors.
// The err_cnt counter and clr_err exist only when LFSR_CHECKER_ERR_CNT_EN is defined.
module lfsr_checker #(
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 63,
  parameter int LOSS_THR = 8
) (
  input  logic           clk,
  input  logic           reset,
  lfsr_checker_if.slave  bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int EW = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t          state, state_n;
  logic [6:1]      sr, sr_n, sr_din;
  logic [2:0]      fill, fill_n;
  logic [MW-1:0]   mcnt, mcnt_n;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [EW-1:0]   werr, werr_n, werr_nx;
  logic            p, err, err_inc;
  logic            locked_q, pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      sr       <= '0;
      fill     <= '0;
      mcnt     <= '0;
      wcnt     <= '0;
      werr     <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      fill     <= fill_n;
      mcnt     <= mcnt_n;
      wcnt     <= wcnt_n;
      werr     <= werr_n;
      locked_q <= (state_n == LOCKED);
      pulse_q  <= err_inc;
    end
  end

  always_comb begin
    p       = sr[5] ~^ sr[6];
    sr_din  = {sr[5:1], bus.din};
    err     = (bus.din != p);
    werr_nx = werr + EW'(err);
    state_n = state;
    sr_n    = sr;
    fill_n  = fill;
    mcnt_n  = mcnt;
    wcnt_n  = wcnt;
    werr_n  = werr;
    err_inc = 1'b0;
    if (bus.din_valid) begin
      case (state)
        HUNT: begin
          sr_n = sr_din;
          if (fill == 3'd5) begin
            state_n = CHECK;
            mcnt_n  = '0;
            fill_n  = '0;
          end else begin
            fill_n = fill + 3'd1;
          end
        end
        CHECK: begin
          sr_n = sr_din;
          // All-ones is the XNOR lockup state and never a valid alignment.
          if (!err && sr_din != 6'b111111) begin
            if (mcnt == MW'(LOCK_CNT - 1)) begin
              state_n = LOCKED;
              wcnt_n  = '0;
              werr_n  = '0;
            end else begin
              mcnt_n = mcnt + MW'(1);
            end
          end else begin
            state_n = HUNT;
            fill_n  = '0;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so corrupted bits never enter the history.
          sr_n    = {sr[5:1], p};
          err_inc = err;
          if (werr_nx >= EW'(LOSS_THR)) begin
            state_n = HUNT;
            fill_n  = '0;
          end else if (wcnt == WW'(WIN - 1)) begin
            wcnt_n = '0;
            werr_n = '0;
          end else begin
            wcnt_n = wcnt + WW'(1);
            werr_n = werr_nx;
          end
        end
        default: begin
          state_n = HUNT;
          fill_n  = '0;
        end
      endcase
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = pulse_q;

`ifdef LFSR_CHECKER_ERR_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            cnt <= '0;
    else if (bus.clr_err)                 cnt <= '0;
    else if (err_inc && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end
  assign bus.err_cnt = cnt;
`else
  logic unused_clr;
  assign unused_clr  = bus.clr_err;
  assign bus.err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, flywheel, loss/relock, window wrap, lockup, gaps, clear, saturation.
// Expected err_cnt values follow LFSR_CHECKER_ERR_CNT_EN (zero when the counter is not built).
module tb_lfsr_checker;
`ifdef LFSR_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_checker_if bus ();
  lfsr_checker_if bus2 ();
  assign bus2.din       = bus.din;
  assign bus2.din_valid = bus.din_valid;
  assign bus2.clr_err   = bus.clr_err;

  lfsr_checker dut (.clk(clk), .reset(reset), .bus(bus));
  // Same stream, threshold above any per-window error total, so lock is held under constant errors.
  lfsr_checker #(.LOSS_THR(64)) dut_sat (.clk(clk), .reset(reset), .bus(bus2));

  int n_run  = 0;
  int n_fail = 0;
  logic [6:1] g;

  function automatic logic [15:0] cexp(input int n);
    return CNT_EN ? n[15:0] : 16'h0000;
  endfunction

  task automatic step(input logic d, input logic v, input logic c);
    @(negedge clk);
    bus.din = d; bus.din_valid = v; bus.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pn(input logic inv);
    step(g[6] ^ inv, 1'b1, 1'b0);
    g = {g[5:1], g[5] ~^ g[6]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    g = '0;
  endtask

  task automatic lock_up();
    do_reset();
    repeat (22) pn(1'b0);
    n_run++;
    if (bus.locked !== 1'b1) begin $display("FAIL lock_up: locked=%b want 1", bus.locked); n_fail++; end
  endtask

  task automatic test_reset();
    #1;
    n_run++;
    if (bus.locked !== 1'b0) begin $display("FAIL rst_locked: %b want 0", bus.locked); n_fail++; end
    n_run++;
    if (bus.err_pulse !== 1'b0) begin $display("FAIL rst_pulse: %b want 0", bus.err_pulse); n_fail++; end
    n_run++;
    if (bus.err_cnt !== 16'h0) begin $display("FAIL rst_cnt: %h want 0", bus.err_cnt); n_fail++; end
  endtask

  task automatic test_clean_lock();
    int pulses = 0, drops = 0;
    do_reset();
    repeat (21) pn(1'b0);
    n_run++;
    if (bus.locked !== 1'b0) begin $display("FAIL lock_early: locked=%b want 0 at 21", bus.locked); n_fail++; end
    pn(1'b0);
    n_run++;
    if (bus.locked !== 1'b1) begin $display("FAIL lock_22: locked=%b want 1", bus.locked); n_fail++; end
    repeat (200) begin
      pn(1'b0);
      if (bus.err_pulse !== 1'b0) pulses++;
      if (bus.locked !== 1'b1) drops++;
    end
    n_run++;
    if (pulses != 0 || drops != 0) begin $display("FAIL clean_run: pulses=%0d drops=%0d want 0/0", pulses, drops); n_fail++; end
    n_run++;
    if (bus.err_cnt !== 16'h0) begin $display("FAIL clean_cnt: %h want 0", bus.err_cnt); n_fail++; end
  endtask

  task automatic test_single_error();
    int pulses = 0, drops = 0;
    lock_up();
    pn(1'b1);
    n_run++;
    if (bus.err_pulse !== 1'b1) begin $display("FAIL single_pulse: %b want 1", bus.err_pulse); n_fail++; end
    n_run++;
    if (bus.err_cnt !== cexp(1)) begin $display("FAIL single_cnt: %h want %h", bus.err_cnt, cexp(1)); n_fail++; end
    repeat (63) begin
      pn(1'b0);
      if (bus.err_pulse !== 1'b0) pulses++;
      if (bus.locked !== 1'b1) drops++;
    end
    n_run++;
    if (pulses != 0 || drops != 0) begin $display("FAIL flywheel: pulses=%0d drops=%0d want 0/0", pulses, drops); n_fail++; end
  endtask

  task automatic test_loss_of_lock();
    int early = 0;
    lock_up();
    for (int i = 0; i < 29; i++) begin
      pn(i % 4 == 0);
      if (i < 28 && bus.locked !== 1'b1) early++;
    end
    n_run++;
    if (early != 0 || bus.locked !== 1'b0) begin $display("FAIL loss: early=%0d locked=%b want 0/0", early, bus.locked); n_fail++; end
    n_run++;
    if (bus.err_cnt !== cexp(8)) begin $display("FAIL loss_cnt: %h want %h", bus.err_cnt, cexp(8)); n_fail++; end
    repeat (21) pn(1'b0);
    n_run++;
    if (bus.locked !== 1'b0) begin $display("FAIL relock_early: locked=%b want 0", bus.locked); n_fail++; end
    pn(1'b0);
    n_run++;
    if (bus.locked !== 1'b1) begin $display("FAIL relock: locked=%b want 1", bus.locked); n_fail++; end
  endtask

  task automatic test_window_wrap();
    int drops = 0;
    lock_up();
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 63; j++) begin
        pn(j % 9 == 0);
        if (bus.locked !== 1'b1) drops++;
      end
    n_run++;
    if (drops != 0) begin $display("FAIL wrap_lock: drops=%0d want 0", drops); n_fail++; end
    n_run++;
    if (bus.err_cnt !== cexp(35)) begin $display("FAIL wrap_cnt: %h want %h", bus.err_cnt, cexp(35)); n_fail++; end
  endtask

  task automatic test_lockup();
    int locks = 0;
    do_reset();
    repeat (100) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus.locked !== 1'b0) locks++;
    end
    n_run++;
    if (locks != 0) begin $display("FAIL lockup: locked seen %0d times want 0", locks); n_fail++; end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      pn(1'b0);
      if (k == 21) begin
        n_run++;
        if (bus.locked !== 1'b0) begin $display("FAIL gap_early: locked=%b want 0", bus.locked); n_fail++; end
      end
      step(1'($urandom_range(1)), 1'b0, 1'b0);
    end
    n_run++;
    if (bus.locked !== 1'b1) begin $display("FAIL gap_lock: locked=%b want 1", bus.locked); n_fail++; end
    pn(1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_run++;
    if (bus.err_pulse !== 1'b0) begin $display("FAIL gap_pulse: %b want 0", bus.err_pulse); n_fail++; end
    n_run++;
    if (bus.err_cnt !== cexp(1)) begin $display("FAIL gap_cnt: %h want %h", bus.err_cnt, cexp(1)); n_fail++; end
  endtask

  task automatic test_clr_err();
    lock_up();
    pn(1'b1);
    step(g[6] ^ 1'b1, 1'b1, 1'b1);
    g = {g[5:1], g[5] ~^ g[6]};
    n_run++;
    if (bus.err_cnt !== 16'h0 || bus.err_pulse !== 1'b1) begin
      $display("FAIL clr_prio: cnt=%h pulse=%b want 0/1", bus.err_cnt, bus.err_pulse); n_fail++;
    end
    pn(1'b1);
    n_run++;
    if (bus.err_cnt !== cexp(1)) begin $display("FAIL clr_resume: %h want %h", bus.err_cnt, cexp(1)); n_fail++; end
    step(1'b0, 1'b0, 1'b1);
    n_run++;
    if (bus.err_cnt !== 16'h0) begin $display("FAIL clr_idle: %h want 0", bus.err_cnt); n_fail++; end
  endtask

  task automatic test_reset_mid_lock();
    lock_up();
    pn(1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    n_run++;
    if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_cnt !== 16'h0) begin
      $display("FAIL mid_reset: locked=%b pulse=%b cnt=%h want 0/0/0", bus.locked, bus.err_pulse, bus.err_cnt); n_fail++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    lock_up();
    for (int i = 1; i <= 70000; i++) begin
      pn(1'b1);
      if (i == 65534) begin
        n_run++;
        if (bus2.err_cnt !== cexp(65534)) begin $display("FAIL sat_pre: %h want %h", bus2.err_cnt, cexp(65534)); n_fail++; end
      end
    end
    n_run++;
    if (bus2.err_cnt !== cexp(65535)) begin $display("FAIL sat_cnt: %h want %h", bus2.err_cnt, cexp(65535)); n_fail++; end
    n_run++;
    if (bus2.locked !== 1'b1) begin $display("FAIL sat_lock: locked=%b want 1", bus2.locked); n_fail++; end
  endtask

  initial begin
    reset = 1'b1; bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr_err = 1'b0; g = '0;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_window_wrap();
    test_lockup();
    test_gaps();
    test_clr_err();
    test_reset_mid_lock();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish within 2000000 time units");
    $fatal(1);
  end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the 6-bit XNOR PN sequence, x[n] = x[n-5] XNOR x[n-6] (period 63, all-ones lockup). It sits at the far end of a link driven by the PN generator's serial output (generator bit 6). It self-synchronises to the incoming stream, declares lock, and flywheels through bit errors. It also reports per-bit errors and a running error count for BER measurement.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive correct predictions required in CHECK before lock.
- WIN, 63: window length in valid bits used for loss-of-lock evaluation.
- LOSS_THR, 8: errors within one window that force loss of lock.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  1  received PN bit.
- din_valid  in  1  qualifies din; all state holds when low.
- clr_err  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle strobe per mismatched bit while LOCKED.
- err_cnt  out  16  saturating count of mismatches while LOCKED.

## Operation
- sr[6:1]: history of the last 6 bits; sr[1] is the newest. Prediction p = sr[5] XNOR sr[6]. A valid bit shifts in as sr <= {sr[5:1], b}.
- HUNT:
  - On each valid bit, b = din; fill counter 0..5 increments.
  - At the 6th bit → CHECK with match counter = 0.
- CHECK:
  - b = din.
  - If din == p and the post-shift sr != 6'b111111: match counter increments. On reaching LOCK_CNT → LOCKED, with window counter and window error count cleared.
  - Otherwise (mismatch, or lockup pattern) → HUNT, fill counter = 0. The shift still happens.
- LOCKED (flywheel):
  - b = p, always; received bits never enter sr.
  - err = (din != p). On err: err_pulse = 1 and err_cnt += 1.
  - werr_next = werr + err.
  - If werr_next >= LOSS_THR: → HUNT, fill counter = 0. This check comes before the window wrap.
  - Else, if window counter == WIN-1: window counter = 0 and werr = 0.
  - Else: window counter += 1 and werr = werr_next.
- err_cnt:
  - Saturates at 16'hFFFF.
  - clr_err has priority over a same-cycle increment; the result is 0.
  - It is not cleared on loss of lock.
- din_valid low: no state, counter or output changes, except that err_pulse returns to 0 and clr_err still acts.
- reset mid-operation: immediate return to HUNT with all counters and outputs at 0, regardless of state.

## Timing
- All outputs are registered. Reset values: locked = 0, err_pulse = 0, err_cnt = 0, sr = 0, state = HUNT.
- err_pulse is high in the cycle after the edge that samples the bad bit, for exactly one cycle per bad bit.
- Lock latency from HUNT with an error-free stream: 6 + LOCK_CNT valid bits. locked rises on the edge that samples the (6+LOCK_CNT)th valid bit, i.e. 22 with the defaults.
- locked falls on the edge that samples the bit making werr_next reach LOSS_THR.
- err_cnt updates on the same edge as err_pulse.
- din_valid may toggle every cycle; gaps stretch all latencies in valid-bit units, not cycles.

## Configuration
- LFSR_CHECKER_ERR_CNT_EN defined: err_cnt counter and clr_err are implemented as above.
- Not defined: err_cnt is tied to 16'h0000 and clr_err is ignored. err_pulse, lock and loss-of-lock behaviour are unchanged.

## Test plan
- Clean lock: drive din from the PN generator's bit 6 with din_valid = 1 continuously after both resets → locked = 1 after exactly 22 valid bits; err_pulse never asserts; err_cnt stays 0 for 200 bits.
- Single error flywheel: after lock, invert one bit → one err_pulse; err_cnt = 1; locked stays 1. The next 63 bits show no further errors, so the inversion did not propagate into sr.
- Loss of lock: after lock, invert 8 bits spaced 4 apart within one window → locked falls on the 8th inverted bit; the checker relocks 22 valid bits after the corruption ends, if the stream is clean.
- Window wrap: 7 errors per 63-bit window, repeated for 5 windows → locked stays 1; err_cnt = 35.
- Lockup rejection: drive all-ones with din_valid = 1 for 100 bits → locked never rises.
- Gaps, reset and clear:
  - Clean stream with din_valid toggling 1/0 → lock after 22 valid bits (about 44 cycles).
  - Assert reset mid-LOCKED → all outputs 0 on the next cycle.
  - Assert clr_err together with an error → err_cnt = 0.
  - Force 70000 errors while LOCKED, with LOSS_THR parameterised high enough to hold lock → err_cnt = 16'hFFFF.
